// File: rtl/seq_divider.sv
// Signed restoring divider: 2*WIDTH-bit dividend by WIDTH-bit divisor, one quotient
// bit per cycle, with fixed latency and divide-by-zero / overflow reporting.
module seq_divider #(
   parameter int WIDTH = 16
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               start_i,
   input  logic [2*WIDTH-1:0] dividend_i,
   input  logic [WIDTH-1:0]   divisor_i,
   output logic [WIDTH-1:0]   quot_o,
   output logic [WIDTH-1:0]   rem_o,
   output logic               busy_o,
   output logic               done_o,
   output logic               dz_o,
   output logic               ovf_o
);

   localparam int CNT_W = $clog2(2*WIDTH);
   localparam logic [2*WIDTH-1:0] POS_LIM = {{(WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
   localparam logic [2*WIDTH-1:0] NEG_LIM = POS_LIM + 1'b1;
   localparam logic [WIDTH-1:0]   SAT_POS = {1'b0, {(WIDTH-1){1'b1}}};
   localparam logic [WIDTH-1:0]   SAT_NEG = {1'b1, {(WIDTH-1){1'b0}}};

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      RUN,
      FIX
   } stateT;

   stateT              state_q;
   logic [2*WIDTH-1:0] dividend_q;
   logic [WIDTH-1:0]   divisor_q;
   logic               signDvd_q;
   logic               signQuot_q;
   logic [2*WIDTH-1:0] quotShift_q;
   logic [WIDTH:0]     partRem_q;
   logic [WIDTH:0]     divisorMag_q;
   logic [CNT_W-1:0]   count_q;
   logic [WIDTH-1:0]   quot_q;
   logic [WIDTH-1:0]   rem_q;
   logic               busy_q;
   logic               done_q;
   logic               dz_q;
   logic               ovf_q;

   logic [2*WIDTH-1:0] dividendMag_d;
   logic [WIDTH:0]     divisorExt;
   logic [WIDTH:0]     divisorMag_d;
   logic [WIDTH+1:0]   shifted;
   logic               trialOk;
   logic [WIDTH:0]     trialDiff;
   logic [WIDTH:0]     partRem_d;
   logic [2*WIDTH-1:0] quotShift_d;
   logic [WIDTH-1:0]   quot_d;
   logic [WIDTH-1:0]   rem_d;
   logic               dz_d;
   logic               ovf_d;

   // Operand magnitudes; the divisor gets one extra bit so the most negative value survives negation.
   always_comb begin
      divisorExt    = {divisor_q[WIDTH-1], divisor_q};
      dividendMag_d = dividend_q[2*WIDTH-1] ? -dividend_q : dividend_q;
      divisorMag_d  = divisorExt[WIDTH] ? -divisorExt : divisorExt;
   end

   always_comb begin
      shifted     = {partRem_q, quotShift_q[2*WIDTH-1]};
      trialOk     = (shifted >= {1'b0, divisorMag_q});
      trialDiff   = shifted[WIDTH:0] - divisorMag_q;
      partRem_d   = trialOk ? trialDiff : shifted[WIDTH:0];
      quotShift_d = {quotShift_q[2*WIDTH-2:0], trialOk};
   end

   // Final sign/saturation stage; the remainder always fits because it is smaller than the divisor.
   always_comb begin
      quot_d = '0;
      dz_d   = 1'b0;
      ovf_d  = 1'b0;
      rem_d  = signDvd_q ? -partRem_q[WIDTH-1:0] : partRem_q[WIDTH-1:0];
      if (divisor_q == '0) begin
         dz_d   = 1'b1;
         quot_d = '1;
         rem_d  = dividend_q[WIDTH-1:0];
      end else if (!signQuot_q && (quotShift_q > POS_LIM)) begin
         ovf_d  = 1'b1;
         quot_d = SAT_POS;
      end else if (signQuot_q && (quotShift_q > NEG_LIM)) begin
         ovf_d  = 1'b1;
         quot_d = SAT_NEG;
      end else begin
         quot_d = signQuot_q ? -quotShift_q[WIDTH-1:0] : quotShift_q[WIDTH-1:0];
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q      <= IDLE;
         dividend_q   <= '0;
         divisor_q    <= '0;
         signDvd_q    <= 1'b0;
         signQuot_q   <= 1'b0;
         quotShift_q  <= '0;
         partRem_q    <= '0;
         divisorMag_q <= '0;
         count_q      <= '0;
         quot_q       <= '0;
         rem_q        <= '0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         dz_q         <= 1'b0;
         ovf_q        <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start_i) begin
                  dividend_q <= dividend_i;
                  divisor_q  <= divisor_i;
                  signDvd_q  <= dividend_i[2*WIDTH-1];
                  signQuot_q <= dividend_i[2*WIDTH-1] ^ divisor_i[WIDTH-1];
                  busy_q     <= 1'b1;
                  state_q    <= LOAD;
               end
            end
            LOAD: begin
               quotShift_q  <= dividendMag_d;
               divisorMag_q <= divisorMag_d;
               partRem_q    <= '0;
               count_q      <= CNT_W'(2*WIDTH-1);
               state_q      <= RUN;
            end
            RUN: begin
               quotShift_q <= quotShift_d;
               partRem_q   <= partRem_d;
               count_q     <= count_q - CNT_W'(1);
               if (count_q == '0) begin
                  state_q <= FIX;
               end
            end
            FIX: begin
               quot_q  <= quot_d;
               rem_q   <= rem_d;
               dz_q    <= dz_d;
               ovf_q   <= ovf_d;
               busy_q  <= 1'b0;
               done_q  <= 1'b1;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign quot_o = quot_q;
   assign rem_o  = rem_q;
   assign busy_o = busy_q;
   assign done_o = done_q;
   assign dz_o   = dz_q;
   assign ovf_o  = ovf_q;

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider: the driver queues expected results from an
// integer-arithmetic model, and a monitor checks every done pulse against the queue.
module tb_seq_divider;

   localparam int W       = 16;
   localparam int LATENCY = 2*W + 2;

   typedef struct {
      logic [W-1:0] q;
      logic [W-1:0] r;
      logic         dz;
      logic         ovf;
      int           edgeNo;
   } expT;

   logic          clk;
   logic          rst;
   logic          start;
   logic [2*W-1:0] dividend;
   logic [W-1:0]  divisor;
   logic [W-1:0]  quot;
   logic [W-1:0]  rem;
   logic          busy;
   logic          done;
   logic          dz;
   logic          ovf;

   expT sb[$];
   int  cycleCount = 0;
   int  checksTotal = 0;
   int  checksPassed = 0;

   seq_divider #(.WIDTH(W)) dut (
      .clk_i      (clk),
      .rst_i      (rst),
      .start_i    (start),
      .dividend_i (dividend),
      .divisor_i  (divisor),
      .quot_o     (quot),
      .rem_o      (rem),
      .busy_o     (busy),
      .done_o     (done),
      .dz_o       (dz),
      .ovf_o      (ovf)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cycleCount <= cycleCount + 1;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checksTotal++;
      if (actual === expected) checksPassed++;
      else $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
   endtask

   task automatic reportFail(input string name);
      checksTotal++;
      $display("[TB] FAIL %s", name);
   endtask

   // Reference: plain signed integer division (truncating), remainder takes the dividend's sign.
   function automatic expT model(input logic [2*W-1:0] dvd, input logic [W-1:0] dvs);
      expT    e;
      longint dd;
      longint dv;
      longint qq;
      longint rr;
      dd = longint'($signed(dvd));
      dv = longint'($signed(dvs));
      e.dz = 1'b0;
      e.ovf = 1'b0;
      e.edgeNo = 0;
      if (dv == 0) begin
         e.dz = 1'b1;
         e.q  = '1;
         e.r  = dvd[W-1:0];
      end else begin
         qq = dd / dv;
         rr = dd % dv;
         e.r = rr[W-1:0];
         if (qq > 32767) begin
            e.ovf = 1'b1;
            e.q   = 16'h7FFF;
         end else if (qq < -32768) begin
            e.ovf = 1'b1;
            e.q   = 16'h8000;
         end else begin
            e.q = qq[W-1:0];
         end
      end
      return e;
   endfunction

   task automatic applyStimulus(input logic [2*W-1:0] dvd, input logic [W-1:0] dvs);
      expT e;
      e = model(dvd, dvs);
      e.edgeNo = cycleCount + 1;
      start    = 1'b1;
      dividend = dvd;
      divisor  = dvs;
      sb.push_back(e);
      @(negedge clk);
      start = 1'b0;
      checkOutput("busy_after_start", {31'd0, busy}, 32'd1);
   endtask

   task automatic waitDone();
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 80 && !seen; i++) begin
         @(negedge clk);
         if (done) seen = 1'b1;
      end
      if (!seen) reportFail("done_timeout");
   endtask

   task automatic checkAllZero(input string tag);
      checkOutput({tag, "_quot"}, {16'd0, quot}, 32'd0);
      checkOutput({tag, "_rem"},  {16'd0, rem},  32'd0);
      checkOutput({tag, "_busy"}, {31'd0, busy}, 32'd0);
      checkOutput({tag, "_done"}, {31'd0, done}, 32'd0);
      checkOutput({tag, "_dz"},   {31'd0, dz},   32'd0);
      checkOutput({tag, "_ovf"},  {31'd0, ovf},  32'd0);
   endtask

   initial begin : monitor
      expT e;
      forever begin
         @(negedge clk);
         if (done) begin
            if (sb.size() == 0) begin
               reportFail("unexpected_done");
            end else begin
               e = sb.pop_front();
               checkOutput("quot",    {16'd0, quot}, {16'd0, e.q});
               checkOutput("rem",     {16'd0, rem},  {16'd0, e.r});
               checkOutput("dz",      {31'd0, dz},   {31'd0, e.dz});
               checkOutput("ovf",     {31'd0, ovf},  {31'd0, e.ovf});
               checkOutput("latency", cycleCount - e.edgeNo, LATENCY);
            end
         end
      end
   end

   logic [2*W-1:0] dirDvd [12];
   logic [W-1:0]   dirDvs [12];

   initial begin : driver
      logic [2*W-1:0] rDvd;
      logic [W-1:0]   rDvs;
      logic [W-1:0]   rq;
      longint         prod;

      dirDvd[0]  = 32'hFBD7D776; dirDvs[0]  = 16'h2813;
      dirDvd[1]  = 32'd100;      dirDvs[1]  = 16'hFFF9;
      dirDvd[2]  = -32'sd100;    dirDvs[2]  = 16'd7;
      dirDvd[3]  = -32'sd100;    dirDvs[3]  = 16'hFFF9;
      dirDvd[4]  = 32'd12345;    dirDvs[4]  = 16'h0000;
      dirDvd[5]  = 32'h00010000; dirDvs[5]  = 16'h0001;
      dirDvd[6]  = 32'h80000000; dirDvs[6]  = 16'hFFFF;
      dirDvd[7]  = 32'hFFFF8000; dirDvs[7]  = 16'h0001;
      dirDvd[8]  = 32'd7;        dirDvs[8]  = 16'h8000;
      dirDvd[9]  = 32'h00007FFF; dirDvs[9]  = 16'h0001;
      dirDvd[10] = 32'hFFFF7FFF; dirDvs[10] = 16'h0001;
      dirDvd[11] = 32'h80000000; dirDvs[11] = 16'h8000;

      rst = 1'b1;
      start = 1'b0;
      dividend = '0;
      divisor = '0;
      repeat (2) @(negedge clk);
      checkAllZero("reset");
      rst = 1'b0;
      @(negedge clk);

      for (int i = 0; i < 12; i++) begin
         applyStimulus(dirDvd[i], dirDvs[i]);
         waitDone();
         @(negedge clk);
      end

      // A start pulse in the middle of a run must be ignored.
      applyStimulus(32'd1000, 16'd33);
      repeat (4) @(negedge clk);
      start = 1'b1;
      dividend = 32'd5;
      divisor = 16'd2;
      @(negedge clk);
      start = 1'b0;
      waitDone();

      // Start issued in the done cycle is accepted straight away.
      applyStimulus(32'hFFFFF000, 16'd3);
      waitDone();
      applyStimulus(32'd77777, 16'hFF00);
      waitDone();
      @(negedge clk);

      // Reset mid-run discards the operation.
      applyStimulus(32'd123456, 16'd321);
      repeat (9) @(negedge clk);
      rst = 1'b1;
      void'(sb.pop_back());
      @(negedge clk);
      rst = 1'b0;
      checkAllZero("midrun_reset");
      repeat (40) @(negedge clk);
      applyStimulus(32'd123456, 16'd321);
      waitDone();
      @(negedge clk);

      // Reset wins over a simultaneous start.
      rst = 1'b1;
      start = 1'b1;
      dividend = 32'd50;
      divisor = 16'd5;
      @(negedge clk);
      rst = 1'b0;
      start = 1'b0;
      checkOutput("rst_start_busy", {31'd0, busy}, 32'd0);
      repeat (40) @(negedge clk);

      for (int n = 0; n < 40; n++) begin
         rDvs = 16'($urandom());
         case ($urandom_range(0, 3))
            0: rDvd = $urandom();
            1: begin
               rq = 16'($urandom());
               prod = longint'($signed(rq)) * longint'($signed(rDvs)) + longint'($urandom_range(0, 15));
               rDvd = prod[2*W-1:0];
            end
            2: rDvd = 32'($signed(16'($urandom())));
            default: begin
               rDvd = $urandom();
               rDvs = ($urandom_range(0, 1) == 0) ? 16'h0000 : 16'h0001;
            end
         endcase
         applyStimulus(rDvd, rDvs);
         waitDone();
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end

      repeat (5) @(negedge clk);
      checkOutput("scoreboard_empty", sb.size(), 32'd0);
      $display("%0d/%0d checks passed", checksPassed, checksTotal);
      $finish;
   end

endmodule
